// File: rtl/z16_mmio_io.sv
// Z16 MMIO responder: LED register, debounced button with sticky press flag and a
// prescaled free-running timer, mapped at 0x007A/0x007C/0x007E on the data bus.
module z16_mmio_io #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned PRESCALE        = 27,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_addr,
    input  logic        i_wen,
    input  logic        i_ren,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    output logic        o_hit,
    input  logic        i_button,
    output logic [5:0]  o_led
);

    localparam logic [15:0] AddrLed   = 16'h007A;
    localparam logic [15:0] AddrBtn   = 16'h007C;
    localparam logic [15:0] AddrTimer = 16'h007E;

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PsW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PsW-1:0]  PsMax  = PsW'(PRESCALE - 1);

    // Address decode
    logic sel_led;
    logic sel_btn;
    logic sel_timer;

    assign sel_led   = (i_addr == AddrLed);
    assign sel_btn   = (i_addr == AddrBtn);
    assign sel_timer = (i_addr == AddrTimer);
    assign o_hit     = sel_led | sel_btn | sel_timer;

    // State
    logic [5:0]      led_q, led_d;
    logic            sync1_q, sync2_q;
    logic            btn_db_q, btn_db_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_evt_q, press_evt_d;
    logic [15:0]     timer_q, timer_d;
    logic [PsW-1:0]  ps_q, ps_d;

    logic btn_norm;
    logic btn_sync;
    logic accept;
    logic tick;

    logic unused_wdata;
    assign unused_wdata = ^i_wdata[15:6];

    // Polarity is normalised before the synchroniser so that reset value 0 means released.
    assign btn_norm = i_button ^ BTN_ACTIVE_LOW;
    assign btn_sync = sync2_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn_norm;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive mismatches.
    always_comb begin
        btn_db_d = btn_db_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        if (btn_sync == btn_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            btn_db_d = btn_sync;
            cnt_d    = '0;
            accept   = 1'b1;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // A press accepted on the same edge as a clearing load wins.
    always_comb begin
        press_evt_d = press_evt_q;
        if (accept && btn_sync) begin
            press_evt_d = 1'b1;
        end else if (i_ren && sel_btn) begin
            press_evt_d = 1'b0;
        end
    end

    assign tick = (ps_q == PsMax);

    always_comb begin
        timer_d = timer_q;
        ps_d    = ps_q;
        if (i_wen && sel_timer) begin
            timer_d = i_wdata;
            ps_d    = '0;
        end else begin
            ps_d    = tick ? '0 : ps_q + PsW'(1);
            timer_d = timer_q + 16'(tick);
        end
    end

    always_comb begin
        led_d = led_q;
        if (i_wen && sel_led) begin
            led_d = i_wdata[5:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            led_q       <= '0;
            btn_db_q    <= 1'b0;
            cnt_q       <= '0;
            press_evt_q <= 1'b0;
            timer_q     <= '0;
            ps_q        <= '0;
        end else begin
            led_q       <= led_d;
            btn_db_q    <= btn_db_d;
            cnt_q       <= cnt_d;
            press_evt_q <= press_evt_d;
            timer_q     <= timer_d;
            ps_q        <= ps_d;
        end
    end

    assign o_led = led_q;

    always_comb begin
        o_rdata = 16'h0000;
        case (i_addr)
            AddrLed:   o_rdata = {10'b0, led_q};
            AddrBtn:   o_rdata = {14'b0, press_evt_q, btn_db_q};
            AddrTimer: o_rdata = timer_q;
            default:   o_rdata = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_z16_mmio_io.sv
// Randomised bench for z16_mmio_io against a cycle-level behavioural model
// (timer derived from cycles elapsed since the last load).
module tb_z16_mmio_io;

    localparam int unsigned DEB = 4;
    localparam int unsigned PRE = 3;
    localparam bit          ACT_LOW = 1'b1;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        hit;
    logic        button;
    logic [5:0]  led;

    int n_checks = 0;
    int n_errors = 0;

    z16_mmio_io #(
        .DEBOUNCE_CYCLES(DEB),
        .PRESCALE       (PRE),
        .BTN_ACTIVE_LOW (ACT_LOW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_addr  (addr),
        .i_wen   (wen),
        .i_ren   (ren),
        .i_wdata (wdata),
        .o_rdata (rdata),
        .o_hit   (hit),
        .i_button(button),
        .o_led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [5:0] m_led;
    bit         m_db;
    bit         m_evt;
    bit         m_p1;
    bit         m_p2;
    int         m_run;
    int         m_base;
    int         m_since;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] m_timer();
        return 16'(m_base + m_since / PRE);
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a);
        case (a)
            16'h007A: return {10'b0, m_led};
            16'h007C: return {14'b0, m_evt, m_db};
            16'h007E: return m_timer();
            default:  return 16'h0000;
        endcase
    endfunction

    function automatic bit m_rise_next();
        return (m_p2 != m_db) && m_p2 && (m_run + 1 == DEB);
    endfunction

    task automatic model_reset();
        m_led = '0; m_db = 0; m_evt = 0; m_p1 = 0; m_p2 = 0;
        m_run = 0; m_base = 0; m_since = 0;
    endtask

    // Applies one rising edge using the inputs the DUT sampled.
    task automatic model_edge();
        bit s;
        bit rose;
        s    = m_p2;
        rose = 0;
        if (s == m_db) begin
            m_run = 0;
        end else if (m_run + 1 == DEB) begin
            m_db  = s;
            m_run = 0;
            rose  = s;
        end else begin
            m_run++;
        end
        if (rose) m_evt = 1;
        else if (ren && addr == 16'h007C) m_evt = 0;
        if (wen && addr == 16'h007A) m_led = wdata[5:0];
        if (wen && addr == 16'h007E) begin
            m_base  = int'(wdata);
            m_since = 0;
        end else begin
            m_since++;
        end
        m_p2 = m_p1;
        m_p1 = ACT_LOW ? ~button : button;
    endtask

    task automatic step();
        @(negedge clk);
        check_eq("hit", {15'b0, hit}, {15'b0, (addr == 16'h007A || addr == 16'h007C ||
                                               addr == 16'h007E)});
        check_eq("rdata", rdata, m_read(addr));
        check_eq("led", {10'b0, led}, {10'b0, m_led});
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_bus(input logic [15:0] a, input logic w, input logic r,
                           input logic [15:0] d);
        addr = a; wen = w; ren = r; wdata = d;
    endtask

    // Asynchronous reset asserted and released away from the clock edge.
    task automatic do_reset();
        logic [15:0] hit_addrs [3];
        hit_addrs[0] = 16'h007A; hit_addrs[1] = 16'h007C; hit_addrs[2] = 16'h007E;
        #3;
        rst_n = 1'b0;
        wen = 1'b0;
        ren = 1'b0;
        #1;
        model_reset();
        check_eq("rst_led", {10'b0, led}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            addr = hit_addrs[i];
            #1;
            check_eq("rst_rdata", rdata, 16'h0000);
            check_eq("rst_hit", {15'b0, hit}, 16'h0001);
        end
        addr = 16'h0078;
        #1;
        check_eq("rst_nohit", {15'b0, hit}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        int hold;
        logic [15:0] addr_pick [5];
        rst_n  = 1'b0;
        button = 1'b1;
        set_bus(16'h0078, 1'b0, 1'b0, 16'h0000);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Timer from reset: 1 after 3 edges, 2 after 6.
        set_bus(16'h007E, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 6; i++) step();
        check_eq("timer_6", rdata, 16'h0002);

        // LED store and a miss store.
        set_bus(16'h007A, 1'b1, 1'b0, 16'hFFE5);
        step();
        set_bus(16'h007A, 1'b0, 1'b1, 16'h0000);
        #1;
        check_eq("led_val", {10'b0, led}, 16'h0025);
        check_eq("led_read", rdata, 16'h0025);
        step();
        set_bus(16'h0078, 1'b1, 1'b0, 16'h0000);
        step();
        check_eq("led_keep", {10'b0, led}, 16'h0025);

        // Timer wrap after load on a tick cycle.
        set_bus(16'h007E, 1'b0, 1'b0, 16'h0000);
        while (m_since % PRE != PRE - 1) step();
        set_bus(16'h007E, 1'b1, 1'b0, 16'hFFFF);
        step();
        set_bus(16'h007E, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            check_eq("timer_hold", rdata, 16'hFFFF);
            step();
        end
        check_eq("timer_wrap", rdata, 16'h0000);

        // Bounce, then a clean press and release.
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        button = 1'b0;
        for (int i = 0; i < 3; i++) step();
        button = 1'b1;
        step();
        button = 1'b0;
        for (int i = 0; i < 12; i++) step();
        check_eq("btn_press", rdata, 16'h0003);
        button = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check_eq("btn_release", rdata, 16'h0002);

        // Clearing load, with write strobe also asserted.
        set_bus(16'h007C, 1'b1, 1'b1, 16'hFFFF);
        step();
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        #1;
        check_eq("evt_clear", rdata, 16'h0000);
        check_eq("btn_wr_led", {10'b0, led}, 16'h0025);

        // Press accepted on the same edge as a clearing load: set wins.
        button = 1'b0;
        for (int i = 0; i < 20 && !m_rise_next(); i++) step();
        check_eq("rise_seen", {15'b0, m_rise_next()}, 16'h0001);
        set_bus(16'h007C, 1'b0, 1'b1, 16'h0000);
        step();
        set_bus(16'h007C, 1'b0, 1'b0, 16'h0000);
        #1;
        check_eq("set_wins", rdata, 16'h0003);

        // Randomised traffic with a mid-run reset.
        addr_pick[0] = 16'h007A; addr_pick[1] = 16'h007C; addr_pick[2] = 16'h007E;
        addr_pick[3] = 16'h0078; addr_pick[4] = 16'h007B;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold == 0) begin
                button = $urandom_range(0, 1);
                hold   = $urandom_range(1, 8);
            end
            hold--;
            if ($urandom_range(0, 9) == 0) addr = 16'($urandom);
            else addr = addr_pick[$urandom_range(0, 4)];
            wen   = ($urandom_range(0, 3) == 0);
            ren   = $urandom_range(0, 1);
            wdata = 16'($urandom);
            if (addr == 16'h007E && $urandom_range(0, 3) != 0) wen = 1'b0;
            if (i == 1500) do_reset();
            else step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
